// File: rtl/range_frame_driver.sv
// Buffers samples and replays them as one go/finish framed burst for the range finder,
// while tracking max/min so the expected range of the frame is available in the done cycle.
module range_frame_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_range,
    output logic             frame_err,
    output logic             wr_drop,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, FIRST, MID, LAST, GAP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    rem, rem_nx;
    logic [WIDTH-1:0] max_q, min_q;
    logic [WIDTH-1:0] head;
    logic             accept, push, pop;

    // Unsigned span; max never falls below min so the subtraction cannot wrap.
    function automatic logic [WIDTH-1:0] span(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
        return hi - lo;
    endfunction

    assign head   = mem[rd_ptr];
    assign accept = (state == IDLE) && start && (count >= CW'(2));
    assign push   = wr_en && (state == IDLE) && !start && (count < CW'(DEPTH));
    assign busy   = (state != IDLE);

    // rem counts the samples still to be shown after the one entering the output register.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = FIRST;
                    rem_nx   = count - CW'(1);
                end
            end
            FIRST, MID: begin
                rem_nx   = rem - CW'(1);
                state_nx = (rem == CW'(1)) ? LAST : MID;
            end
            LAST:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign pop = (state_nx == FIRST) || (state_nx == MID) || (state_nx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rf_go     <= 1'b0;
            rf_finish <= 1'b0;
            rf_data   <= '0;
            done      <= 1'b0;
            exp_range <= '0;
            frame_err <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            rf_go     <= (state_nx == FIRST);
            rf_finish <= (state_nx == LAST);
            rf_data   <= pop ? head : '0;
            done      <= (state_nx == GAP);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (state_nx == GAP) exp_range <= span(max_q, min_q);
            if (accept)                             frame_err <= 1'b0;
            else if ((state == IDLE) && start)      frame_err <= 1'b1;
            // A write dropped in the accepting cycle must still be flagged.
            if (wr_en && !push) wr_drop <= 1'b1;
            else if (accept)    wr_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop) begin
            if (state_nx == FIRST) begin
                max_q <= head;
                min_q <= head;
            end else begin
                if (head > max_q) max_q <= head;
                if (head < min_q) min_q <= head;
            end
        end
    end

endmodule
